// File: rtl/tgate_bank_cfg.sv
// tgate_bank_cfg: bank of WIDTH one-way transmission-gate channels whose
// enables are loaded through a serial shadow chain and applied on commit.
// Optional build macro CFG_PARITY_EN adds one even-parity bit to the chain;
// a commit is then accepted only when the whole chain has even parity.
module tgate_bank_cfg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_in,
   input  logic             cfg_shift_en,
   input  logic             cfg_commit,
   output logic             cfg_out,
   output logic             cfg_done,
   output logic             cfg_err,
   input  logic [WIDTH-1:0] b,
   output wire  [WIDTH-1:0] a
);

`ifdef CFG_PARITY_EN
   localparam int CHAIN_LEN = WIDTH + 1;
`else
   localparam int CHAIN_LEN = WIDTH;
`endif

   // Counter must reach CHAIN_LEN+1 so an over-shift is distinguishable.
   localparam int CW = $clog2(CHAIN_LEN + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN_LEN);
   localparam logic [CW-1:0] CNT_SAT  = CW'(CHAIN_LEN + 1);

   typedef enum logic {IDLE, LOADING} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CHAIN_LEN-1:0] shadow;
   logic [CW-1:0]        bit_cnt;
   logic [WIDTH-1:0]     active;
   logic                 commit_try;
   logic                 commit_ok;
   logic                 parity_ok;

`ifdef CFG_PARITY_EN
   // Even parity over the full chain, data bits plus the trailing parity bit.
   function automatic logic even_parity(input logic [CHAIN_LEN-1:0] v);
      return ~(^v);
   endfunction
   assign parity_ok = even_parity(shadow);
`else
   assign parity_ok = 1'b1;
`endif

   // A shift in the same cycle wins; the commit request is then ignored.
   assign commit_try = cfg_commit & ~cfg_shift_en;
   assign commit_ok  = commit_try && (state == LOADING) &&
                       (bit_cnt == CNT_FULL) && parity_ok;

   assign cfg_out = shadow[CHAIN_LEN-1];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: first shift starts a load, any commit attempt ends it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cfg_shift_en) state_nxt = LOADING;
         LOADING: if (commit_try)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shadow chain: first bit shifted in ends up at the MSB; never cleared by commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            shadow <= '0;
      else if (cfg_shift_en) shadow <= (shadow << 1) | CHAIN_LEN'(cfg_in);
   end

   // Bit counter: saturating count of shifts since the last commit attempt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
      end else if (cfg_shift_en) begin
         if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
      end else if (commit_try) begin
         bit_cnt <= '0;
      end
   end

   // Active enables take the top WIDTH chain bits on an accepted commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         active <= '0;
      else if (commit_ok) active <= shadow[CHAIN_LEN-1 -: WIDTH];
   end

   // Status: one-cycle done pulse; error sticks until the next good commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_done <= commit_ok;
         if (commit_ok)       cfg_err <= 1'b0;
         else if (commit_try) cfg_err <= 1'b1;
      end
   end

   // Each channel passes b through when enabled and floats otherwise.
   for (genvar i = 0; i < WIDTH; i++) begin : g_gate
      assign a[i] = active[i] ? b[i] : 1'bz;
   end

endmodule
